// File: rtl/instr_loader_pkg.sv
// Shared loader definitions: opcode values decoded by the control unit, halt marker, FSM encodings.
// opcode_ok() backs the optional INSTR_LOADER_OPCODE_CHECK_EN build of instr_loader.
package instr_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWU   = 6'h27;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  function automatic logic opcode_ok(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU,
      OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs MSB-first bytes into 32-bit words; word_vld_o is combinational on the 4th accepted byte.
module instr_loader_word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_vld_i) begin
      shift_q <= {shift_q[15:0], byte_dat_i};
      idx_q   <= idx_q + 2'd1;
    end
  end

  // The completed word includes the byte arriving this cycle, so no extra stage is needed.
  assign word_o     = {shift_q, byte_dat_i};
  assign word_vld_o = byte_vld_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Boot loader: byte stream -> big-endian words written to imem from address 0; releases cpu_run on the halt word.
// Optional feature macro INSTR_LOADER_OPCODE_CHECK_EN rejects words with unsupported opcodes.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              cpu_run_o,
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              asm_clear;
  logic              asm_vld;
  logic [31:0]       asm_word;

  // rx_ready depends only on state so the byte handshake has no comb loop through next-state logic.
  assign rx_ready_o = (state_q == S_RECV);

  instr_loader_word_assembler u_asm (
    .clk_i      (clk_i),
    .rst_i      (reset_i),
    .clear_i    (asm_clear),
    .byte_vld_i (rx_valid_i && rx_ready_o),
    .byte_dat_i (rx_data_i),
    .word_vld_o (asm_vld),
    .word_o     (asm_word)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    word_d    = word_q;
    asm_clear = 1'b0;
    imem_we_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    error_o   = 1'b0;
    cpu_run_o = 1'b0;
    case (state_q)
      S_RECV: begin
        busy_o = 1'b1;
        if (asm_vld) begin
          if (asm_word == HALT_WORD) begin
            state_d = S_DONE;
          end else if (count_q == DEPTH) begin
            state_d = S_ERR;
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
          end else if (!opcode_ok(asm_word[31:26])) begin
            state_d = S_ERR;
`endif
          end else begin
            word_d  = asm_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        busy_o    = 1'b1;
        imem_we_o = 1'b1;
        addr_d    = addr_q + 1'b1;
        if (count_q != DEPTH) count_d = count_q + 1'b1;
        state_d   = S_RECV;
      end
      default: begin
        done_o    = (state_q == S_DONE);
        cpu_run_o = (state_q == S_DONE);
        error_o   = (state_q == S_ERR);
        if (start_i) begin
          state_d   = S_RECV;
          addr_d    = '0;
          count_d   = '0;
          asm_clear = 1'b1;
        end
      end
    endcase
  end

  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = word_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench: DUT a (ADDR_W=10) for normal loads, DUT b (ADDR_W=2) for overflow.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_vld = 1'b0, a_rdy, a_we, a_busy, a_done, a_err, a_run;
  logic [7:0]  a_dat = 8'h00;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_cnt;

  logic        b_start = 1'b0, b_vld = 1'b0, b_rdy, b_we, b_busy, b_done, b_err, b_run;
  logic [7:0]  b_dat = 8'h00;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_cnt;

  instr_loader #(.ADDR_W(10)) u_a (
    .clk_i(clk), .reset_i(rst), .start_i(a_start), .rx_data_i(a_dat), .rx_valid_i(a_vld),
    .rx_ready_o(a_rdy), .imem_we_o(a_we), .imem_addr_o(a_addr), .imem_wdata_o(a_wdata),
    .busy_o(a_busy), .done_o(a_done), .error_o(a_err), .cpu_run_o(a_run), .word_count_o(a_cnt)
  );

  instr_loader #(.ADDR_W(2)) u_b (
    .clk_i(clk), .reset_i(rst), .start_i(b_start), .rx_data_i(b_dat), .rx_valid_i(b_vld),
    .rx_ready_o(b_rdy), .imem_we_o(b_we), .imem_addr_o(b_addr), .imem_wdata_o(b_wdata),
    .busy_o(b_busy), .done_o(b_done), .error_o(b_err), .cpu_run_o(b_run), .word_count_o(b_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] aq_dat[$];
  logic [9:0]  aq_addr[$];
  logic [31:0] bq_dat[$];
  logic [1:0]  bq_addr[$];
  int a_viol = 0;

  always @(negedge clk) begin
    if (a_we) begin
      aq_dat.push_back(a_wdata);
      aq_addr.push_back(a_addr);
      if (a_rdy) a_viol++;
    end
    if (b_we) begin
      bq_dat.push_back(b_wdata);
      bq_addr.push_back(b_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input bit to_b);
    if (to_b) b_start = 1'b1; else a_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    a_start = 1'b0;
  endtask

  task automatic send(input bit to_b, input logic [7:0] b, input int gap);
    int n;
    bit got;
    if (to_b) begin b_dat = b; b_vld = 1'b1; end
    else      begin a_dat = b; a_vld = 1'b1; end
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (to_b ? b_rdy : a_rdy) got = 1'b1;
      tick(1);
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL handshake_timeout: observed no rx_ready expected rx_ready within 40 cycles");
    end
    a_vld = 1'b0;
    b_vld = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input bit to_b, input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    send(to_b, t[31:24], gap);
    send(to_b, t[23:16], gap);
    send(to_b, t[15:8], gap);
    send(to_b, t[7:0], gap);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_rdy", a_rdy, 1'b0);
    check("rst_we", a_we, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_run", a_run, 1'b0);
    check("rst_cnt", a_cnt, 11'd0);
    check("rst_addr", a_addr, 10'd0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // Test 1: two words then halt, back-to-back bytes
    pulse_start(1'b0);
    check("t1_busy", a_busy, 1'b1);
    send_word(1'b0, 32'h2008_0005, 0);
    check("t1_lat_we", a_we, 1'b1);
    check("t1_lat_rdy", a_rdy, 1'b0);
    check("t1_lat_dat", a_wdata, 32'h2008_0005);
    send_word(1'b0, 32'h0000_0000, 0);
    send_word(1'b0, 32'hFFFF_FFFF, 0);
    check("t1_done_now", a_done, 1'b1);
    tick(2);
    check("t1_nwr", aq_dat.size(), 2);
    check("t1_d0", aq_dat[0], 32'h2008_0005);
    check("t1_a0", aq_addr[0], 10'd0);
    check("t1_d1", aq_dat[1], 32'h0000_0000);
    check("t1_a1", aq_addr[1], 10'd1);
    check("t1_run", a_run, 1'b1);
    check("t1_busy_end", a_busy, 1'b0);
    check("t1_cnt", a_cnt, 11'd2);

    // Test 6a: start in DONE restarts at address 0
    aq_dat.delete();
    aq_addr.delete();
    pulse_start(1'b0);
    check("t6_run_drop", a_run, 1'b0);
    check("t6_done_drop", a_done, 1'b0);
    check("t6_busy", a_busy, 1'b1);
    check("t6_cnt_clr", a_cnt, 11'd0);
    check("t6_addr_clr", a_addr, 10'd0);

    // Test 2 + 6b: valid toggling, start pulsed mid-word is ignored
    send(1'b0, 8'h20, 1);
    send(1'b0, 8'h08, 1);
    pulse_start(1'b0);
    send(1'b0, 8'h00, 1);
    send(1'b0, 8'h05, 1);
    send_word(1'b0, 32'h0000_0000, 1);
    send_word(1'b0, 32'hFFFF_FFFF, 1);
    tick(2);
    check("t2_nwr", aq_dat.size(), 2);
    check("t2_d0", aq_dat[0], 32'h2008_0005);
    check("t2_a0", aq_addr[0], 10'd0);
    check("t2_d1", aq_dat[1], 32'h0000_0000);
    check("t2_a1", aq_addr[1], 10'd1);
    check("t2_rdy_in_write", a_viol, 0);
    check("t2_done", a_done, 1'b1);
    check("t2_cnt", a_cnt, 11'd2);

    // Test 3: ADDR_W=2 overflow on the fifth word
    pulse_start(1'b1);
    send_word(1'b1, 32'h2001_0001, 0);
    send_word(1'b1, 32'h2002_0002, 0);
    send_word(1'b1, 32'h2003_0003, 0);
    send_word(1'b1, 32'h2004_0004, 0);
    send_word(1'b1, 32'h2405_0005, 0);
    tick(2);
    check("t3_nwr", bq_dat.size(), 4);
    check("t3_a0", bq_addr[0], 2'd0);
    check("t3_d3", bq_dat[3], 32'h2004_0004);
    check("t3_a3", bq_addr[3], 2'd3);
    check("t3_err", b_err, 1'b1);
    check("t3_cnt", b_cnt, 3'd4);
    check("t3_run", b_run, 1'b0);
    check("t3_busy", b_busy, 1'b0);

    // Test 4: reset mid-word discards partial bytes
    aq_dat.delete();
    aq_addr.delete();
    pulse_start(1'b0);
    send(1'b0, 8'hAA, 0);
    send(1'b0, 8'hBB, 0);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", a_busy, 1'b0);
    check("t4_rst_cnt", a_cnt, 11'd0);
    check("t4_rst_rdy", a_rdy, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);
    pulse_start(1'b0);
    send_word(1'b0, 32'h8C01_0004, 0);
    send_word(1'b0, 32'hFFFF_FFFF, 0);
    tick(2);
    check("t4_nwr", aq_dat.size(), 1);
    check("t4_d0", aq_dat[0], 32'h8C01_0004);
    check("t4_a0", aq_addr[0], 10'd0);
    check("t4_done", a_done, 1'b1);

    // Test 5: unsupported opcode
    aq_dat.delete();
    aq_addr.delete();
    pulse_start(1'b0);
    send_word(1'b0, 32'hFC00_0000, 0);
`ifdef INSTR_LOADER_OPCODE_CHECK_EN
    tick(2);
    check("t5_nwr", aq_dat.size(), 0);
    check("t5_err", a_err, 1'b1);
    check("t5_cnt", a_cnt, 11'd0);
    check("t5_run", a_run, 1'b0);
`else
    send_word(1'b0, 32'hFFFF_FFFF, 0);
    tick(2);
    check("t5_nwr", aq_dat.size(), 1);
    check("t5_d0", aq_dat[0], 32'hFC00_0000);
    check("t5_a0", aq_addr[0], 10'd0);
    check("t5_done", a_done, 1'b1);
    check("t5_err", a_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
